mdu_seq: RTL and testbench
==========================

# mdu_seq

Multi-cycle multiply/divide unit that extends the single-cycle datapath ALU with MIPS-style HI/LO arithmetic. It supports signed and unsigned multiply and divide, plus direct HI/LO writes, over a parametrised operand width with configurable latencies. It sits beside the ALU in the EX stage. Its `busy` output drives the pipeline stall logic, and its HI/LO registers feed the mfhi/mflo read path.

## Interface
Parameters:
- `WIDTH`, default 32: operand and HI/LO width.
- `MUL_CYCLES`, default 5: multiply latency in cycles, ≥1.
- `DIV_CYCLES`, default 10: divide latency in cycles, ≥1.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `start` input 1: qualifies `op` for one cycle.
- `op` input 3: operation select.
  - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO.
  - 110 and 111 are no-ops.
- `A` input WIDTH: first operand (rs); also the MTHI/MTLO source.
- `B` input WIDTH: second operand (rt).
- `busy` output 1: high while a multiply or divide is in flight.
- `HI` output WIDTH: HI register.
- `LO` output WIDTH: LO register.

## Operation
- FSM states:
  - IDLE: `busy`=0.
  - RUN: `busy`=1, with a down-counter of width $clog2(max(MUL_CYCLES,DIV_CYCLES))+1.
- IDLE with `start`=1 and `op` in 000–011:
  - Compute the result from the `A`/`B` sampled that cycle.
  - Latch the result into shadow registers `pHI`/`pLO`.
  - Load the counter with the op's latency and go to RUN.
  - `A`/`B` may change afterward without effect.
- RUN: decrement the counter each cycle. When the counter reaches the final cycle:
  - Copy `pHI`/`pLO` into `HI`/`LO`.
  - Return to IDLE.
- MULT/MULTU: form the 2·WIDTH-bit product, signed or unsigned. `HI` gets the upper half, `LO` the lower half.
- DIV/DIVU results:
  - `LO` = quotient, truncated toward zero.
  - `HI` = remainder, carrying the sign of the dividend (`A`).
- DIV boundary cases:
  - Most-negative / −1: `LO` = most-negative value, `HI` = 0 (no trap).
  - B=0, signed or unsigned: full `DIV_CYCLES` busy period, then `HI`/`LO` keep their prior values.
- MTHI/MTLO in IDLE with `start`=1: `HI` (or `LO`) ← `A` at that edge. `busy` stays 0 and the other register is unchanged.
- `start`=1 while in RUN, any op (including MTHI/MTLO): ignored completely. The pipeline is required to stall instead.
- `start`=1 with op 110/111: no state change.
- Behavioural `*`, `/`, `%` are allowed for the result computation. Only the registered interface timing is normative.

## Timing
- Reset: `busy`=0, `HI`=0, `LO`=0, FSM=IDLE, counter=0. Shadow registers are cleared to 0.
- Start sampled at edge t0 (latency N = `MUL_CYCLES` or `DIV_CYCLES`):
  - `busy`=1 from after t0 until edge t0+N.
  - `HI`/`LO` update at edge t0+N; `busy`=0 after that edge.
  - `busy` is therefore high for exactly N cycles.
- Back-to-back: a new `start` is accepted in the cycle immediately after `busy` falls. Zero idle gap is required.
- MTHI/MTLO: `HI`/`LO` visible the cycle after the start edge.
- Reset mid-operation, at any RUN cycle:
  - At the next edge: `busy`=0 and `HI`=`LO`=0.
  - The pending result is discarded and never committed.
- Reset has priority over `start` in the same cycle.
- `HI`/`LO` are stable throughout RUN, holding the old values until commit.

## Test plan
Defaults: WIDTH=32, MUL_CYCLES=5, DIV_CYCLES=10.
- MULT A=0xFFFFFFFE, B=0x00000003 -> `busy` high exactly 5 cycles, then `HI`=0xFFFFFFFF, `LO`=0xFFFFFFFA; `HI`/`LO` unchanged during RUN.
- MULTU with the same operands -> `HI`=0x00000002, `LO`=0xFFFFFFFA after 5 cycles.
- DIV A=0xFFFFFFF9 (−7), B=2 -> after 10 cycles `LO`=0xFFFFFFFD, `HI`=0xFFFFFFFF. Then DIVU A=7, B=2 issued the cycle `busy` falls -> `LO`=3, `HI`=1.
- DIV A=0x80000000, B=0xFFFFFFFF -> `LO`=0x80000000, `HI`=0. Then DIVU A=5, B=0 -> 10 busy cycles, `HI`/`LO` retain 0x00000000/0x80000000.
- MTHI A=0x12345678 -> `HI`=0x12345678 next cycle, `busy` never asserted. Start MULT 3×4, and during RUN issue MTLO A=0xDEADBEEF plus another MULT -> both ignored; final `HI`=0, `LO`=0x0000000C.
- MULT 3×4, assert `reset` on the 3rd busy cycle -> next cycle `busy`=0, `HI`=`LO`=0, and `LO` remains 0 for ≥5 further cycles.

Source files
------------

// File: rtl/mdu_seq.sv
// Multi-cycle multiply/divide unit with MIPS-style HI/LO registers.
// The result is computed when start is accepted and committed to HI/LO after the op's latency.
module mdu_seq #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES) + 1;

    localparam logic [CW-1:0] MUL_LAT  = CW'(MUL_CYCLES);
    localparam logic [CW-1:0] DIV_LAT  = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_r, state_s;
    logic [CW-1:0]    cnt_r, cnt_s;
    logic [WIDTH-1:0] phi_r, phi_s;
    logic [WIDTH-1:0] plo_r, plo_s;
    logic [WIDTH-1:0] hi_r, hi_s;
    logic [WIDTH-1:0] lo_r, lo_s;
    logic             busy_r, busy_s;

    logic [2*WIDTH-1:0] sprod_s;
    logic [2*WIDTH-1:0] uprod_s;
    logic               a_neg_s;
    logic               b_neg_s;
    logic               b_zero_s;
    logic [WIDTH-1:0]   a_mag_s;
    logic [WIDTH-1:0]   b_mag_s;
    logic [WIDTH-1:0]   qmag_s;
    logic [WIDTH-1:0]   rmag_s;
    logic [WIDTH-1:0]   sq_s;
    logic [WIDTH-1:0]   sr_s;
    logic [WIDTH-1:0]   uq_s;
    logic [WIDTH-1:0]   ur_s;

    assign sprod_s = $signed({{WIDTH{A[WIDTH-1]}}, A}) * $signed({{WIDTH{B[WIDTH-1]}}, B});
    assign uprod_s = {ZERO_W, A} * {ZERO_W, B};

    // Signed divide via magnitudes: avoids the most-negative/-1 overflow and
    // gives truncation toward zero with the remainder following the dividend.
    assign a_neg_s  = A[WIDTH-1];
    assign b_neg_s  = B[WIDTH-1];
    assign b_zero_s = (B == ZERO_W);
    assign a_mag_s  = a_neg_s ? (ZERO_W - A) : A;
    assign b_mag_s  = b_neg_s ? (ZERO_W - B) : B;
    assign qmag_s   = a_mag_s / b_mag_s;
    assign rmag_s   = a_mag_s % b_mag_s;
    assign sq_s     = (a_neg_s ^ b_neg_s) ? (ZERO_W - qmag_s) : qmag_s;
    assign sr_s     = a_neg_s ? (ZERO_W - rmag_s) : rmag_s;
    assign uq_s     = A / B;
    assign ur_s     = A % B;

    // Next-state, counter, shadow and HI/LO update logic.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        phi_s   = phi_r;
        plo_s   = plo_r;
        hi_s    = hi_r;
        lo_s    = lo_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT: begin
                            phi_s   = sprod_s[2*WIDTH-1:WIDTH];
                            plo_s   = sprod_s[WIDTH-1:0];
                            cnt_s   = MUL_LAT;
                            state_s = RUN;
                        end
                        OP_MULTU: begin
                            phi_s   = uprod_s[2*WIDTH-1:WIDTH];
                            plo_s   = uprod_s[WIDTH-1:0];
                            cnt_s   = MUL_LAT;
                            state_s = RUN;
                        end
                        OP_DIV: begin
                            // Divide by zero commits the current HI/LO, i.e. they keep their values.
                            phi_s   = b_zero_s ? hi_r : sr_s;
                            plo_s   = b_zero_s ? lo_r : sq_s;
                            cnt_s   = DIV_LAT;
                            state_s = RUN;
                        end
                        OP_DIVU: begin
                            phi_s   = b_zero_s ? hi_r : ur_s;
                            plo_s   = b_zero_s ? lo_r : uq_s;
                            cnt_s   = DIV_LAT;
                            state_s = RUN;
                        end
                        OP_MTHI: hi_s = A;
                        OP_MTLO: lo_s = A;
                        default: state_s = IDLE;
                    endcase
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (cnt_r == CNT_ONE) begin
                    hi_s    = phi_r;
                    lo_s    = plo_r;
                    cnt_s   = CNT_ZERO;
                    state_s = IDLE;
                end else begin
                    cnt_s   = cnt_r - CNT_ONE;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = CNT_ZERO;
            end
        endcase
        busy_s = (state_s == RUN);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
            phi_r   <= ZERO_W;
            plo_r   <= ZERO_W;
            hi_r    <= ZERO_W;
            lo_r    <= ZERO_W;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            phi_r   <= phi_s;
            plo_r   <= plo_s;
            hi_r    <= hi_s;
            lo_r    <= lo_s;
            busy_r  <= busy_s;
        end
    end

    assign busy = busy_r;
    assign HI   = hi_r;
    assign LO   = lo_r;

endmodule

// File: tb/tb_mdu_seq.sv
// Scoreboard bench for mdu_seq: stimulus pushes expected HI/LO/latency, a monitor
// checks them when busy falls and checks HI/LO stay stable while busy.
module tb_mdu_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
        string       name;
    } exp_t;

    exp_t sb_q[$];

    mdu_seq #(.WIDTH(32), .MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .HI    (HI),
        .LO    (LO)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] hi, input logic [31:0] lo, input int lat, input string name);
        exp_t e;
        e.hi = hi; e.lo = lo; e.lat = lat; e.name = name;
        sb_q.push_back(e);
    endtask

    // Drive one start cycle from a falling edge, then scramble A/B to show they are not re-read.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; op = o; A = a; B = b;
        @(negedge clk);
        start = 1'b0; A = $urandom; B = $urandom;
    endtask

    task automatic wait_done(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s: busy still 1 after 40 cycles, required 0", name);
        end
    endtask

    // Monitor: counts busy cycles, checks HI/LO stability during RUN and pops on commit.
    initial begin : monitor
        logic        prev_busy;
        int          bcnt;
        logic [31:0] hold_hi;
        logic [31:0] hold_lo;
        exp_t        e;
        prev_busy = 1'b0;
        bcnt      = 0;
        hold_hi   = 32'h0;
        hold_lo   = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                bcnt = 0;
            end else if (busy) begin
                if (!prev_busy) begin
                    hold_hi = HI;
                    hold_lo = LO;
                end else begin
                    check("run_hi_stable", HI, hold_hi);
                    check("run_lo_stable", LO, hold_lo);
                end
                bcnt++;
            end else if (prev_busy) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_commit: got HI=0x%08h LO=0x%08h, required no commit", HI, LO);
                end else begin
                    e = sb_q.pop_front();
                    check({e.name, "_hi"}, HI, e.hi);
                    check({e.name, "_lo"}, LO, e.lo);
                    check({e.name, "_busy_cycles"}, 32'(bcnt), 32'(e.lat));
                end
                bcnt = 0;
            end
            prev_busy = busy;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        reset = 1'b1; start = 1'b0; op = 3'b000; A = 32'h0; B = 32'h0;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_hi", HI, 32'h0);
        check("reset_lo", LO, 32'h0);
        reset = 1'b0;

        push(32'hFFFF_FFFF, 32'hFFFF_FFFA, 5, "mult");
        issue(3'b000, 32'hFFFF_FFFE, 32'h0000_0003);
        wait_done("mult");

        push(32'h0000_0002, 32'hFFFF_FFFA, 5, "multu");
        issue(3'b001, 32'hFFFF_FFFE, 32'h0000_0003);
        wait_done("multu");

        push(32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, "div_neg7_2");
        issue(3'b010, 32'hFFFF_FFF9, 32'h0000_0002);
        wait_done("div_neg7_2");
        push(32'h0000_0001, 32'h0000_0003, 10, "divu_b2b");
        issue(3'b011, 32'h0000_0007, 32'h0000_0002);
        wait_done("divu_b2b");

        push(32'h0000_0000, 32'h8000_0000, 10, "div_min_m1");
        issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("div_min_m1");
        push(32'h0000_0000, 32'h8000_0000, 10, "divu_by0");
        issue(3'b011, 32'h0000_0005, 32'h0000_0000);
        wait_done("divu_by0");

        issue(3'b100, 32'h1234_5678, 32'h0);
        check("mthi_hi", HI, 32'h1234_5678);
        check("mthi_lo", LO, 32'h8000_0000);
        check("mthi_busy", 32'(busy), 32'h0);

        issue(3'b110, 32'hAAAA_AAAA, 32'h5555_5555);
        check("nop_hi", HI, 32'h1234_5678);
        check("nop_lo", LO, 32'h8000_0000);
        check("nop_busy", 32'(busy), 32'h0);

        push(32'h0000_0000, 32'h0000_000C, 5, "mult_3x4");
        issue(3'b000, 32'h0000_0003, 32'h0000_0004);
        issue(3'b101, 32'hDEAD_BEEF, 32'h0);
        issue(3'b000, 32'h0000_0005, 32'h0000_0006);
        wait_done("mult_3x4");
        @(negedge clk);
        check("ignored_ops_lo", LO, 32'h0000_000C);

        issue(3'b000, 32'h0000_0003, 32'h0000_0004);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_hi", HI, 32'h0);
        check("abort_lo", LO, 32'h0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("abort_lo_hold", LO, 32'h0);
            check("abort_busy_hold", 32'(busy), 32'h0);
        end

        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending entries, required 0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
